// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the commit arbiter
package core_pkg;

    localparam int STARVE_CNT_W = 4;
    localparam int CORE_XLEN    = 32;
    localparam int CORE_RIDX_W  = 5;
    localparam int CORE_SRC_W   = 3;

    localparam logic [STARVE_CNT_W-1:0] WAIT_MAX = '1;

    typedef struct packed {
        logic [CORE_RIDX_W-1:0] rd;
        logic [CORE_XLEN-1:0]   data;
        logic [CORE_XLEN-1:0]   pc;
        logic [CORE_SRC_W-1:0]  src;
    } commit_entry_t;

    // A single source still needs a one-bit index field.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_commit_arb_if.sv
// rtl/core_commit_arb_if.sv - request and commit port bundle of the commit arbiter
interface core_commit_arb_if
    import core_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
);
    localparam int SRC_W = src_width(NREQ);

    logic [NREQ-1:0]        req_val;
    logic [NREQ-1:0]        req_rdy;
    logic [NREQ*RIDX_W-1:0] req_rd;
    logic [NREQ*XLEN-1:0]   req_data;
    logic [NREQ*XLEN-1:0]   req_pc;

    logic                   commit_val;
    logic                   commit_rdy;
    logic [SRC_W-1:0]       commit_src;
    logic [RIDX_W-1:0]      commit_rd;
    logic [XLEN-1:0]        commit_data;
    logic [XLEN-1:0]        commit_pc;
    logic                   starve_evt;

    modport master (
        input  req_val, req_rd, req_data, req_pc, commit_rdy,
        output req_rdy, commit_val, commit_src, commit_rd, commit_data, commit_pc, starve_evt
    );

    modport slave (
        output req_val, req_rd, req_data, req_pc, commit_rdy,
        input  req_rdy, commit_val, commit_src, commit_rd, commit_data, commit_pc, starve_evt
    );

endinterface

// File: rtl/core_rr_arb.sv
// rtl/core_rr_arb.sv - round-robin picker with a forced-priority override vector
module core_rr_arb #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [NREQ-1:0]  force_vec,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_forced
);

    logic found;
    int   pos;

    always_comb begin
        gnt_idx    = '0;
        found      = 1'b0;
        pos        = 0;
        gnt_forced = |force_vec;
        if (gnt_forced) begin
            // descending scan leaves the lowest forced index as the winner
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (force_vec[i]) begin
                    gnt_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                pos = (int'(ptr) + k) % NREQ;
                if (!found && req[pos]) begin
                    found   = 1'b1;
                    gnt_idx = IDX_W'(pos);
                end
            end
        end
        gnt = (|req) ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/core_commit_arb.sv
// rtl/core_commit_arb.sv - shares the single commit port among NREQ result sources
module core_commit_arb
    import core_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int XLEN      = 32,
    parameter int RIDX_W    = 5,
    parameter int STARVE_TH = 7
) (
    input logic             clk,
    input logic             rst,
    core_commit_arb_if.master bus
);

    localparam int SRC_W = src_width(NREQ);

    logic                    free;
    logic [NREQ-1:0]         elig;
    logic [NREQ-1:0]         force_vec;
    logic [NREQ-1:0]         gnt;
    logic [SRC_W-1:0]        gnt_idx;
    logic                    gnt_forced;
    logic                    any_gnt;
    logic [SRC_W-1:0]        rr_ptr;
    logic [STARVE_CNT_W-1:0] wait_cnt [NREQ];
    logic                    commit_val_q;
    commit_entry_t           entry_q;
    commit_entry_t           entry_d;

    // Load is allowed while the current entry drains; nothing is offered in reset.
    assign free = rst && (!commit_val_q || bus.commit_rdy);
    assign elig = bus.req_val & {NREQ{free}};

    always_comb begin
        force_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            force_vec[i] = elig[i] && (wait_cnt[i] >= STARVE_CNT_W'(STARVE_TH));
        end
    end

    core_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (SRC_W)
    ) u_rr_arb (
        .req        (elig),
        .ptr        (rr_ptr),
        .force_vec  (force_vec),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_forced (gnt_forced)
    );

    assign any_gnt = |gnt;

    always_comb begin
        entry_d = entry_q;
        if (any_gnt) begin
            entry_d.rd   = CORE_RIDX_W'(bus.req_rd[gnt_idx*RIDX_W +: RIDX_W]);
            entry_d.data = CORE_XLEN'(bus.req_data[gnt_idx*XLEN +: XLEN]);
            entry_d.pc   = CORE_XLEN'(bus.req_pc[gnt_idx*XLEN +: XLEN]);
            entry_d.src  = CORE_SRC_W'(gnt_idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_val_q <= 1'b0;
            entry_q      <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (any_gnt) begin
                commit_val_q <= 1'b1;
            end else if (bus.commit_rdy) begin
                commit_val_q <= 1'b0;
            end
            entry_q <= entry_d;
            if (any_gnt) begin
                rr_ptr <= (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] || !bus.req_val[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WAIT_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.req_rdy     = gnt;
    assign bus.starve_evt  = any_gnt && gnt_forced;
    assign bus.commit_val  = commit_val_q;
    assign bus.commit_src  = SRC_W'(entry_q.src);
    assign bus.commit_rd   = RIDX_W'(entry_q.rd);
    assign bus.commit_data = XLEN'(entry_q.data);
    assign bus.commit_pc   = XLEN'(entry_q.pc);

    a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.req_rdy));
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        (commit_val_q && !bus.commit_rdy) |=> $stable(entry_q));
    a_src_range: assert property (@(posedge clk) disable iff (!rst)
        commit_val_q |-> (int'(entry_q.src) < NREQ));

endmodule

// File: tb/tb_core_commit_arb.sv
// tb/tb_core_commit_arb.sv - randomized scoreboard bench for core_commit_arb
module tb_core_commit_arb;

    localparam int NREQ      = 3;
    localparam int XLEN      = 32;
    localparam int RIDX_W    = 5;
    localparam int STARVE_TH = 3;

    typedef struct {
        int          src;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    core_commit_arb_if #(.NREQ(NREQ), .XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();

    core_commit_arb #(
        .NREQ      (NREQ),
        .XLEN      (XLEN),
        .RIDX_W    (RIDX_W),
        .STARVE_TH (STARVE_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          pend [NREQ];
    logic [4:0]  s_rd [NREQ];
    logic [31:0] s_data [NREQ];
    logic [31:0] s_pc [NREQ];
    bit          rdy_drv = 1'b0;
    int          m_rr;
    int          m_wait [NREQ];
    bit          m_cv;
    int          last_gnt;
    int          dut_starve = 0;
    int          rr_seq [6];
    int          want_seq [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_val[i]                     = pend[i];
            bus.req_rd[i*RIDX_W +: RIDX_W]     = s_rd[i];
            bus.req_data[i*XLEN +: XLEN]       = s_data[i];
            bus.req_pc[i*XLEN +: XLEN]         = s_pc[i];
        end
        bus.commit_rdy = rdy_drv;
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_cv = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            m_wait[i] = 0;
            pend[i]   = 1'b0;
        end
        exp_q.delete();
    endtask

    // Reference: starvation first (lowest index), else first pending at/after rr pointer.
    task automatic model_step();
        int  gnt;
        int  w;
        bit  forced;
        bit  free;
        int  exp_rdy;
        gnt    = -1;
        forced = 1'b0;
        free   = !m_cv || rdy_drv;
        if (free) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt < 0 && pend[i] && m_wait[i] >= STARVE_TH) begin
                    gnt    = i;
                    forced = 1'b1;
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                w = (m_rr + k) % NREQ;
                if (gnt < 0 && pend[w]) gnt = w;
            end
        end
        exp_rdy = (gnt < 0) ? 0 : (1 << gnt);
        chk("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
        chk("starve_evt", 64'(bus.starve_evt), 64'(forced));
        chk("commit_val", 64'(bus.commit_val), 64'(m_cv));
        if (bus.starve_evt) dut_starve++;
        for (int i = 0; i < NREQ; i++) begin
            if (i == gnt)     m_wait[i] = 0;
            else if (pend[i]) m_wait[i] = (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
            else              m_wait[i] = 0;
        end
        if (gnt >= 0) begin
            exp_q.push_back('{gnt, s_rd[gnt], s_data[gnt], s_pc[gnt]});
            m_rr      = (gnt + 1) % NREQ;
            m_cv      = 1'b1;
            pend[gnt] = 1'b0;
        end else if (rdy_drv) begin
            m_cv = 1'b0;
        end
        last_gnt = gnt;
    endtask

    task automatic cycle(input logic [NREQ-1:0] new_mask, input bit rdy);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && new_mask[i]) begin
                pend[i]   = 1'b1;
                s_rd[i]   = 5'($urandom);
                s_data[i] = $urandom;
                s_pc[i]   = $urandom;
            end
        end
        rdy_drv = rdy;
        drive();
        @(negedge clk);
        model_step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_val"}, 64'(bus.commit_val), 64'd0);
        chk({tag, "_src"}, 64'(bus.commit_src), 64'd0);
        chk({tag, "_rd"}, 64'(bus.commit_rd), 64'd0);
        chk({tag, "_data"}, 64'(bus.commit_data), 64'd0);
        chk({tag, "_pc"}, 64'(bus.commit_pc), 64'd0);
        chk({tag, "_rdy"}, 64'(bus.req_rdy), 64'd0);
        chk({tag, "_starve"}, 64'(bus.starve_evt), 64'd0);
    endtask

    // Scoreboard monitor: every accepted commit must match the oldest predicted entry.
    always @(negedge clk) begin
        if (rst && bus.commit_val && rdy_drv) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL commit_unexpected: got src %0d with empty scoreboard at %0t", bus.commit_src, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_src", 64'(bus.commit_src), 64'(mon_e.src));
                chk("commit_rd", 64'(bus.commit_rd), 64'(mon_e.rd));
                chk("commit_data", 64'(bus.commit_data), 64'(mon_e.data));
                chk("commit_pc", 64'(bus.commit_pc), 64'(mon_e.pc));
            end
        end
    end

    initial begin
        want_seq = '{0, 1, 2, 0, 1, 2};
        model_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                pend[i]   = 1'($urandom);
                s_rd[i]   = 5'($urandom);
                s_data[i] = $urandom;
                s_pc[i]   = $urandom;
            end
            rdy_drv = 1'($urandom);
            drive();
            @(negedge clk);
            chk_all_zero("reset");
        end
        model_reset();
        rdy_drv = 1'b1;
        drive();
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 3; c++) cycle('0, 1'b1);

        for (int c = 0; c < 6; c++) begin
            cycle('1, 1'b1);
            rr_seq[c] = last_gnt;
        end
        for (int c = 0; c < 6; c++) chk("rr_order", 64'(rr_seq[c]), 64'(want_seq[c]));

        for (int c = 0; c < 4; c++) begin
            cycle('1, 1'b0);
            if (exp_q.size() > 0) begin
                chk("hold_src", 64'(bus.commit_src), 64'(exp_q[0].src));
                chk("hold_data", 64'(bus.commit_data), 64'(exp_q[0].data));
                chk("hold_pc", 64'(bus.commit_pc), 64'(exp_q[0].pc));
            end
        end
        for (int c = 0; c < 6; c++) cycle('1, 1'b1);
        for (int c = 0; c < 5; c++) cycle('0, 1'b1);

        pend[1]   = 1'b1;
        s_rd[1]   = 5'd5;
        s_data[1] = 32'hDEADBEEF;
        s_pc[1]   = 32'h100;
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        chk("single_val", 64'(bus.commit_val), 64'd1);
        chk("single_src", 64'(bus.commit_src), 64'd1);
        chk("single_rd", 64'(bus.commit_rd), 64'd5);
        chk("single_data", 64'(bus.commit_data), 64'hDEADBEEF);
        chk("single_pc", 64'(bus.commit_pc), 64'h100);

        for (int c = 0; c < 300; c++) begin
            cycle(NREQ'($urandom), ($urandom_range(0, 2) != 0));
        end

        cycle('1, 1'b1);
        cycle('1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) cycle('0, 1'b1);

        for (int c = 0; c < 8; c++) cycle('0, 1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        tests++;
        if (dut_starve == 0) begin
            fails++;
            $display("FAIL starve_seen: got %0d forced grants expected at least 1", dut_starve);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
